prg_arbiter: RTL and testbench
==============================

Name: prg_arbiter

Overview:
- Shares one PseudorandomGenerator instance between NUM_REQ consumers in the genetic-algorithm datapath, e.g. selection, crossover and mutation units.
- Grants requesters round-robin, pulses the generator's start, waits for its done, and returns the 8-bit value to the granted requester.
- Owns the generator's seed register and supports seed reload between draws.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, watchdog limit in cycles for prg_done; used only with PRG_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester draw request, level; held until the matching rnd_valid bit.
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- rnd_value  out  8  drawn value, meaningful only while rnd_valid is nonzero.
- rnd_valid  out  NUM_REQ  one-cycle one-hot pulse, value ready for the granted requester.
- seed_load  in  1  one-cycle request to load seed_in.
- seed_in  in  32  new seed.
- prg_start  out  1  start to the generator.
- prg_seed  out  32  seed to the generator (in_seed).
- prg_value  in  8  generator value.
- prg_done  in  1  generator done, level.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky timeout flag; tied 0 without PRG_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt=0, rnd_valid=0, rnd_value=0, prg_start=0, busy=0, err=0.
  - prg_seed=32'd2682981917; rr pointer=0; seed_pending=0; armed=0.
- States: IDLE, SEED, START, WAIT, DELIVER.
- Seed reload:
  - seed_load in any state latches seed_in into a shadow register and sets seed_pending.
  - A second seed_load before it is applied overwrites the shadow; last value wins.
- IDLE:
  - seed_pending takes priority over any req: go to SEED.
  - Else, if req is nonzero, grant the first asserted req at or after the rr pointer (wrapping), set gnt, go to START.
- SEED: prg_seed <= shadow, seed_pending <= 0, return to IDLE. Costs 1 cycle; no grant is issued in this cycle.
- START:
  - prg_start=1 for exactly one cycle; armed <= 0; go to WAIT.
  - prg_seed never changes while state is START, WAIT or DELIVER.
- WAIT:
  - While prg_done=0, set armed <= 1.
  - When armed=1 and prg_done=1: capture rnd_value <= prg_value and go to DELIVER.
  - A prg_done left high from a previous draw is ignored until it has been seen low once.
- DELIVER:
  - rnd_valid = gnt for 1 cycle; gnt deasserts at the end of this cycle.
  - rr pointer <= granted index + 1 (mod NUM_REQ); go to IDLE.
- Latency: req to rnd_valid = 3 cycles + generator latency, minimum 4 cycles.
- Throughput: back-to-back draws need one IDLE cycle between DELIVER and the next START.
- Requests:
  - req is sampled only in IDLE.
  - A req bit dropped mid-transaction does not abort it; the value is still delivered.
  - req for the currently granted index must be low or re-asserted by the requester to be granted again.
- Fairness: with all req high, grants cycle 0,1,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transactions.
- rnd_value holds its last value between draws.

Optional Feature:
- Macro PRG_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without an accepted done: set err (sticky until reset), deassert gnt with no rnd_valid, advance the rr pointer past the granted index, go to IDLE.
- Undefined: no counter; WAIT waits indefinitely; err is constant 0.

Test Plan:
- Reset then idle: after reset, prg_seed=2682981917, all outputs 0, busy=0. req=4'b0001, model done 3 cycles after start -> gnt=0001 for the transaction, prg_start one-cycle pulse, rnd_valid=0001 with rnd_value equal to model value.
- Round-robin: req=4'b1111 held -> grant order 0,1,2,3,0; rnd_valid pulses one-hot in that order.
- Seed reload: seed_load with seed_in=1928682902 during WAIT -> current draw completes; SEED cycle follows; prg_seed=1928682902 before the next prg_start.
- Stale done: model holds prg_done high after a draw; second draw -> value not captured until done has gone low then high again.
- Async reset mid-WAIT: drop rst_n -> gnt, prg_start, busy cleared immediately with no clk edge; no rnd_valid.
- With PRG_TIMEOUT_EN and TIMEOUT=8: model never asserts done -> after 8 WAIT cycles err=1, gnt=0, state IDLE; next req is granted to the following index.

Source files
------------

// File: rtl/prg_arbiter.sv
// prg_arbiter: shares one pseudorandom generator between NUM_REQ consumers.
// Requesters are served round-robin. Each draw pulses prg_start, waits for a
// fresh prg_done, and returns the 8-bit value to the granted requester.
// The generator seed is owned here and can be reloaded between draws.
// Optional: define PRG_TIMEOUT_EN to add a prg_done watchdog that sets a sticky err.
module prg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [7:0]         rnd_value,
    output logic [NUM_REQ-1:0] rnd_valid,
    input  logic               seed_load,
    input  logic [31:0]        seed_in,
    output logic               prg_start,
    output logic [31:0]        prg_seed,
    input  logic [7:0]         prg_value,
    input  logic               prg_done,
    output logic               busy,
    output logic               err
);
    localparam int          IW         = $clog2(NUM_REQ);
    localparam logic [31:0] SEED_RESET = 32'd2682981917;

    typedef enum logic [2:0] {IDLE, SEED, START, WAIT, DELIVER} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rnd_valid_q, rnd_valid_d;
    logic [7:0]         rnd_value_q, rnd_value_d;
    logic               prg_start_q, prg_start_d;
    logic               busy_q, busy_d;
    logic [31:0]        prg_seed_q, prg_seed_d;
    logic [31:0]        shadow_q, shadow_d;
    logic               seed_pending_q, seed_pending_d;
    logic               armed_q, armed_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;

    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      cand_idx;
    logic [IW-1:0]      next_ptr;

`ifdef PRG_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic          err_q, err_d;
    logic [WW-1:0] wdog_q, wdog_d;
`endif

    // Round-robin pick: first asserted req at or after the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_idx = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Pointer value that moves the round-robin start just past the granted index.
    assign next_ptr = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + IW'(1);

    // Next-state and output computation for the draw sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
        state_d        = state_q;
        gnt_d          = gnt_q;
        rnd_valid_d    = '0;
        rnd_value_d    = rnd_value_q;
        prg_start_d    = 1'b0;
        prg_seed_d     = prg_seed_q;
        shadow_d       = shadow_q;
        seed_pending_d = seed_pending_q;
        armed_d        = armed_q;
        ptr_d          = ptr_q;
        gidx_d         = gidx_q;
`ifdef PRG_TIMEOUT_EN
        err_d          = err_q;
        wdog_d         = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (seed_pending_q) begin
                    state_d = SEED;
                end else if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gidx_d          = pick_idx;
                    prg_start_d     = 1'b1;
                    state_d         = START;
                end
            end
            SEED: begin
                prg_seed_d     = shadow_q;
                seed_pending_d = 1'b0;
                state_d        = IDLE;
            end
            START: begin
                armed_d = 1'b0;
                state_d = WAIT;
`ifdef PRG_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                // A done still high from the previous draw only counts after it was seen low.
                if (!prg_done) armed_d = 1'b1;
                if (armed_q && prg_done) begin
                    rnd_value_d = prg_value;
                    rnd_valid_d = gnt_q;
                    state_d     = DELIVER;
                end
`ifdef PRG_TIMEOUT_EN
                else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
`endif
            end
            DELIVER: begin
                gnt_d   = '0;
                ptr_d   = next_ptr;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Seed loads are accepted in every state; the latest one wins.
        if (seed_load) begin
            shadow_d       = seed_in;
            seed_pending_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the seed shadow is reset along with everything else so prg_seed never loads an unknown value.
        if (!rst_n) begin
            state_q        <= IDLE;
            gnt_q          <= '0;
            rnd_valid_q    <= '0;
            rnd_value_q    <= '0;
            prg_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            prg_seed_q     <= SEED_RESET;
            shadow_q       <= SEED_RESET;
            seed_pending_q <= 1'b0;
            armed_q        <= 1'b0;
            ptr_q          <= '0;
            gidx_q         <= '0;
`ifdef PRG_TIMEOUT_EN
            err_q          <= 1'b0;
            wdog_q         <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            rnd_valid_q    <= rnd_valid_d;
            rnd_value_q    <= rnd_value_d;
            prg_start_q    <= prg_start_d;
            busy_q         <= busy_d;
            prg_seed_q     <= prg_seed_d;
            shadow_q       <= shadow_d;
            seed_pending_q <= seed_pending_d;
            armed_q        <= armed_d;
            ptr_q          <= ptr_d;
            gidx_q         <= gidx_d;
`ifdef PRG_TIMEOUT_EN
            err_q          <= err_d;
            wdog_q         <= wdog_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_value = rnd_value_q;
    assign prg_start = prg_start_q;
    assign prg_seed  = prg_seed_q;
    assign busy      = busy_q;
`ifdef PRG_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_prg_arbiter.sv
// Testbench for prg_arbiter: random request rounds, a behavioural generator
// with stale done levels, random seed reloads, and a scoreboard monitor.
module tb_prg_arbiter;
    localparam int          N          = 4;
    localparam logic [31:0] SEED_RESET = 32'd2682981917;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [7:0]     rnd_value;
    logic [N-1:0]   rnd_valid;
    logic           seed_load;
    logic [31:0]    seed_in;
    logic           prg_start;
    logic [31:0]    prg_seed;
    logic [7:0]     prg_value;
    logic           prg_done;
    logic           busy;
    logic           err;

    prg_arbiter #(.NUM_REQ(N), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .rnd_value (rnd_value),
        .rnd_valid (rnd_valid),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .prg_start (prg_start),
        .prg_seed  (prg_seed),
        .prg_value (prg_value),
        .prg_done  (prg_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    int          model_ptr;
    int          exp_idx_q[$];
    logic [7:0]  val_q[$];
    logic [31:0] cur_seed;
    logic [31:0] pend_seed;
    bit          has_pend;
    bit          prev_start;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural generator: may keep an old done level high for a while,
    // then drops done for 2..4 cycles and raises it with a fresh value.
    initial begin
        int         stale;
        int         low;
        logic [7:0] v;
        prg_done  = 1'b0;
        prg_value = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst_n && prg_start) begin
                stale = $urandom_range(2);
                low   = $urandom_range(4, 2);
                repeat (stale) begin @(posedge clk); #1; end
                prg_done = 1'b0;
                repeat (low) begin @(posedge clk); #1; end
                v = 8'($urandom);
                if (v == prg_value) v = v + 8'd1;
                prg_value = v;
                prg_done  = 1'b1;
                val_q.push_back(v);
                @(posedge clk); #1;
                if ($urandom_range(1) == 1) prg_done = 1'b0;
            end
        end
    end

    // Monitor: checks starts, seed stability and every delivered value.
    initial begin
        int         idx;
        logic [7:0] v;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prg_start) begin
                    if (has_pend) begin
                        cur_seed = pend_seed;
                        has_pend = 1'b0;
                    end
                    check("start_single_cycle", 64'(prev_start), 64'd0);
                    check("start_gnt_onehot", 64'($onehot(gnt)), 64'd1);
                    check("seed_at_start", prg_seed, cur_seed);
                end else if (gnt != '0) begin
                    check("seed_stable", prg_seed, cur_seed);
                end
                if (rnd_valid != '0) begin
                    if (exp_idx_q.size() == 0 || val_q.size() == 0) begin
                        check("unexpected_valid", rnd_valid, 64'd0);
                    end else begin
                        idx = exp_idx_q.pop_front();
                        v   = val_q.pop_front();
                        check("valid_index", rnd_valid, 64'(1) << idx);
                        check("gnt_at_valid", gnt, 64'(1) << idx);
                        check("rnd_value", rnd_value, v);
                    end
                end
            end
            prev_start = prg_start;
        end
    end

    // One round: raise mask, release each bit on its rnd_valid, optionally reload seeds.
    task automatic do_round(input logic [N-1:0] mask, input bit force_seed, input logic [31:0] fseed);
        int  last;
        int  budget;
        bit  forced_done;
        last = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (model_ptr + k) % N;
            if (mask[idx]) begin
                exp_idx_q.push_back(idx);
                last = idx;
            end
        end
        model_ptr   = (last + 1) % N;
        forced_done = 1'b0;
        req         = mask;
        budget      = 0;
        while (req != '0 && budget < 500) begin
            @(posedge clk); #1;
            budget++;
            if (seed_load) begin
                seed_load = 1'b0;
                pend_seed = seed_in;
                has_pend  = 1'b1;
            end
            if (rnd_valid != '0) req = req & ~rnd_valid;
            if (gnt != '0 && !prg_start) begin
                if (force_seed && !forced_done) begin
                    seed_in     = fseed;
                    seed_load   = 1'b1;
                    forced_done = 1'b1;
                end else if (!force_seed && $urandom_range(7) == 0) begin
                    seed_in   = $urandom;
                    seed_load = 1'b1;
                end
            end
        end
        if (seed_load) begin
            @(posedge clk); #1;
            seed_load = 1'b0;
            pend_seed = seed_in;
            has_pend  = 1'b1;
        end
        if (req != '0) check("round_timeout", req, 64'd0);
    endtask

    initial begin
        int budget;
        rst_n     = 1'b0;
        req       = '0;
        seed_load = 1'b0;
        seed_in   = '0;
        model_ptr = 0;
        cur_seed  = SEED_RESET;
        has_pend  = 1'b0;
        #23;
        check("rst_gnt", gnt, 64'd0);
        check("rst_rnd_valid", rnd_valid, 64'd0);
        check("rst_rnd_value", rnd_value, 64'd0);
        check("rst_prg_start", prg_start, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_err", err, 64'd0);
        check("rst_prg_seed", prg_seed, SEED_RESET);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single requester, then round-robin with everyone requesting.
        do_round(4'b0001, 1'b0, '0);
        do_round(4'b1111, 1'b0, '0);
        do_round(4'b1111, 1'b0, '0);
        // Directed seed reload while a draw is in flight.
        do_round(4'b0110, 1'b1, 32'd1928682902);
        do_round(4'b1001, 1'b0, '0);
        check("seed_reloaded", prg_seed, 32'd1928682902);

        // Random rounds.
        for (int r = 0; r < 30; r++) begin
            do_round(N'($urandom_range(15, 1)), 1'b0, '0);
            repeat ($urandom_range(3)) begin @(posedge clk); #1; end
        end

        // Async reset in the middle of WAIT.
        repeat (3) begin @(posedge clk); #1; end
        exp_idx_q.push_back(0);
        req    = 4'b0001;
        budget = 0;
        while (!prg_start && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("reset_test_start_seen", 64'(prg_start), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", gnt, 64'd0);
        check("async_rst_prg_start", prg_start, 64'd0);
        check("async_rst_busy", busy, 64'd0);
        check("async_rst_rnd_valid", rnd_valid, 64'd0);
        req = '0;
        repeat (12) @(posedge clk);
        exp_idx_q.delete();
        val_q.delete();
        model_ptr = 0;
        cur_seed  = SEED_RESET;
        has_pend  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_prg_seed", prg_seed, SEED_RESET);
        @(posedge clk); #1;
        do_round(4'b1010, 1'b0, '0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_idx_q.size()), 64'd0);
        check("final_err", err, 64'd0);
        check("final_idle", busy, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
